// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, training, imem and IF/ID signals.
// The slave side is the fetch stage; the master side is the hazard unit, ID and the imem model.
interface fetch_stage_if;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_pred_taken;
  logic [31:0] ifid_pred_target;

  modport slave (
    input  pc_write, ifid_write, ifid_flush, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, imem_rdata,
    output imem_addr, pc, ifid_instr, ifid_pc4, ifid_pred_taken, ifid_pred_target
  );

  modport master (
    output pc_write, ifid_write, ifid_flush, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, imem_rdata,
    input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_pred_taken, ifid_pred_target
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, direct-mapped BTB with 2-bit counters, IF/ID register.
// Lookup is combinational on pc; training writes land on the edge, so same-cycle lookups see old contents.
module fetch_btb_entry #(
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic             upd_taken,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      target,
  output logic [1:0]       ctr
);
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  ctr_e state, state_nxt;
  logic hit;

  assign hit = valid && (tag == upd_tag);
  assign ctr = state;

  always_ff @(posedge clk) begin
    if (rst) state <= STRONG_NT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (upd_en) begin
      if (hit) begin
        if (upd_taken) begin
          case (state)
            STRONG_NT: state_nxt = WEAK_NT;
            WEAK_NT:   state_nxt = WEAK_T;
            default:   state_nxt = STRONG_T;
          endcase
        end else begin
          case (state)
            STRONG_T: state_nxt = WEAK_T;
            WEAK_T:   state_nxt = WEAK_NT;
            default:  state_nxt = STRONG_NT;
          endcase
        end
      end else if (upd_taken) begin
        state_nxt = WEAK_T;
      end
    end
  end

  // A taken update writes tag/target whether it hits (retarget) or misses (allocate).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
    end else if (upd_en && upd_taken) begin
      valid  <= 1'b1;
      tag    <= upd_tag;
      target <= upd_target;
    end
  end
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  fetch_stage_if.slave bus
);
  localparam int ENTRIES = 2 ** BTB_IDX_W;
  localparam int TAG_W   = 32 - BTB_IDX_W - 2;

  logic [31:0] pc_q;
  logic [31:0] pc4;
  logic [31:0] pred_next;
  logic        pred_taken;
  logic        hit;

  logic [BTB_IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0]     tag, upd_tag;

  logic [ENTRIES-1:0]             btb_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  btb_tag;
  logic [ENTRIES-1:0][31:0]       btb_target;
  logic [ENTRIES-1:0][1:0]        btb_ctr;

  logic unused_upd_lsb;
  assign unused_upd_lsb = ^bus.upd_pc[1:0];

  assign idx     = pc_q[BTB_IDX_W+1:2];
  assign tag     = pc_q[31:BTB_IDX_W+2];
  assign upd_idx = bus.upd_pc[BTB_IDX_W+1:2];
  assign upd_tag = bus.upd_pc[31:BTB_IDX_W+2];

  genvar e;
  generate
    for (e = 0; e < ENTRIES; e++) begin : g_btb
      localparam logic [BTB_IDX_W-1:0] ENT = e;
      fetch_btb_entry #(.TAG_W(TAG_W)) u_entry (
        .clk        (clk),
        .rst        (rst),
        .upd_en     (bus.upd_valid && (upd_idx == ENT)),
        .upd_taken  (bus.upd_taken),
        .upd_tag    (upd_tag),
        .upd_target (bus.upd_target),
        .valid      (btb_valid[e]),
        .tag        (btb_tag[e]),
        .target     (btb_target[e]),
        .ctr        (btb_ctr[e])
      );
    end
  endgenerate

  assign hit        = btb_valid[idx] && (btb_tag[idx] == tag);
  assign pred_taken = hit && btb_ctr[idx][1];
  assign pc4        = pc_q + 32'd4;
  assign pred_next  = pred_taken ? btb_target[idx] : pc4;

  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;

  // Redirect must win over a stall so a mispredict is never lost behind a load-use hold.
  always_ff @(posedge clk) begin
    if (rst)                     pc_q <= RESET_PC;
    else if (bus.redirect_valid) pc_q <= bus.redirect_pc;
    else if (bus.pc_write)       pc_q <= pred_next;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.ifid_flush || bus.redirect_valid) begin
      bus.ifid_instr       <= NOP_INSTR;
      bus.ifid_pc4         <= '0;
      bus.ifid_pred_taken  <= 1'b0;
      bus.ifid_pred_target <= '0;
    end else if (bus.ifid_write) begin
      bus.ifid_instr       <= bus.imem_rdata;
      bus.ifid_pc4         <= pc4;
      bus.ifid_pred_taken  <= pred_taken;
      bus.ifid_pred_target <= pred_taken ? btb_target[idx] : 32'd0;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic vs. an array-based model.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          IW     = 4;
  localparam int          NENT   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .BTB_IDX_W(IW), .NOP_INSTR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc, instr, pc4, ptgt;
    logic        pt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_ptgt;
  logic        m_pt;
  bit          bv[NENT];
  logic [31:0] btgt[NENT];
  logic [31:0] btag[NENT];
  int          bctr[NENT];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("imem_addr", bus.imem_addr, e.pc);
        chk("ifid_instr", bus.ifid_instr, e.instr);
        chk("ifid_pc4", bus.ifid_pc4, e.pc4);
        chk("ifid_pred_taken", {31'd0, bus.ifid_pred_taken}, {31'd0, e.pt});
        chk("ifid_pred_target", bus.ifid_pred_target, e.ptgt);
      end
    end
  end

  // One clock: drive inputs at negedge, advance the model to the post-edge state, queue it.
  task automatic step(input bit r, input bit pw, input bit iw, input bit fl,
                      input bit rv, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utg, input logic [31:0] rd);
    int i, ui, c;
    bit h, pt, uh;
    logic [31:0] nxt, tgt;
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.pc_write = pw; bus.ifid_write = iw; bus.ifid_flush = fl;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
    bus.imem_rdata = rd;
    if (r) begin
      m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_pt = 0; m_ptgt = 0;
      for (int k = 0; k < NENT; k++) begin bv[k] = 0; bctr[k] = 0; btgt[k] = 0; btag[k] = 0; end
    end else begin
      i   = int'((m_pc / 4) % NENT);
      h   = bv[i] && (btag[i] == m_pc / (4 * NENT));
      pt  = h && (bctr[i] >= 2);
      tgt = btgt[i];
      nxt = pt ? tgt : m_pc + 32'd4;
      if (fl || rv) begin
        m_instr = 0; m_pc4 = 0; m_pt = 0; m_ptgt = 0;
      end else if (iw) begin
        m_instr = rd; m_pc4 = m_pc + 32'd4; m_pt = pt; m_ptgt = pt ? tgt : 32'd0;
      end
      if (rv)      m_pc = rpc;
      else if (pw) m_pc = nxt;
      if (uv) begin
        ui = int'((upc / 4) % NENT);
        uh = bv[ui] && (btag[ui] == upc / (4 * NENT));
        c  = bctr[ui];
        if (uh && ut)       begin bctr[ui] = (c == 3) ? 3 : c + 1; btgt[ui] = utg; end
        else if (uh)        bctr[ui] = (c == 0) ? 0 : c - 1;
        else if (ut)        begin bv[ui] = 1; btag[ui] = upc / (4 * NENT); btgt[ui] = utg; bctr[ui] = 2; end
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.pt = m_pt; e.ptgt = m_ptgt;
    q.push_back(e);
    @(posedge clk);
  endtask

  // common shorthands
  task automatic run(input logic [31:0] rd);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, rd);
  endtask
  task automatic train(input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    step(0, 0, 0, 0, 0, 0, 1, upc, ut, utg, 32'hDEAD_0000);
  endtask
  task automatic redir(input logic [31:0] rpc);
    step(0, 1, 1, 0, 1, rpc, 0, 0, 0, 0, 32'hDEAD_0001);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1;
    bus.pc_write = 0; bus.ifid_write = 0; bus.ifid_flush = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    bus.upd_target = 0; bus.imem_rdata = 0;

    // reset and free-run
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    run(32'h1111_1111); run(32'h2222_2222);
    // stall at 0x3008 with IF/ID held
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3333_3333);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3333_3333);
    run(32'h3333_3333);
    // flush beats hold
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h4444_4444);
    // allocate taken entry for 0x3010, then fetch it
    train(32'h3010, 1, 32'h3040);
    redir(32'h3010);
    run(32'h5555_5555);
    run(32'h6666_6666);
    // two not-taken updates saturate to strongly not taken
    train(32'h3010, 0, 0);
    train(32'h3010, 0, 0);
    redir(32'h3010);
    run(32'h7777_7777);
    run(32'h8888_8888);
    // redirect during a stall, IF/ID still takes the bubble
    step(0, 0, 1, 0, 1, 32'h3100, 0, 0, 0, 0, 32'h9999_9999);
    run(32'hAAAA_AAAA);
    // same-index update and lookup in one cycle after a fresh reset
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run(1); run(2); run(3); run(4);
    step(0, 1, 1, 0, 0, 0, 1, 32'h3010, 1, 32'h3080, 32'h0000_0005);
    redir(32'h3010);
    run(32'h0000_0006);
    run(32'h0000_0007);
    // reset during a redirect clears everything
    step(1, 0, 1, 1, 1, 32'h3200, 1, 32'h3000, 1, 32'h3300, 32'hBBBB_BBBB);
    run(32'hCCCC_CCCC); run(32'hDDDD_DDDD);

    // random traffic confined to a small window so indices and tags alias often
    for (int n = 0; n < 1500; n++) begin
      a = 32'h3000 + ($urandom_range(0, 63) << 2);
      b = 32'h3000 + ($urandom_range(0, 63) << 2);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10, a,
           $urandom_range(0, 99) < 40, b, 1'($urandom_range(0, 1)),
           32'h3000 + ($urandom_range(0, 63) << 2), $urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
